// File: rtl/branch_fb_queue.sv
// Two-wide resolved-branch feedback FIFO feeding the gshare predictor write ports.
// Drains only on predictor ports fetch leaves idle; owns the global history register.
// Optional same-cycle bypass when empty: define BRFB_BYPASS_EN.
module branch_fb_queue #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned HISTORY_WIDTH = 14
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [1:0]                         in_valid,
    input  logic [1:0][ADDR_WIDTH-1:0]         in_pc,
    input  logic [1:0]                         in_taken,
    output logic                               in_ready,
    input  logic [1:0]                         rd_demand,
    output logic [1:0]                         out_valid,
    output logic [1:0][ADDR_WIDTH-1:0]         out_pc,
    output logic [1:0]                         out_taken,
    output logic [HISTORY_WIDTH-1:0]           ghist,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               overflow_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_WIDTH-1:0]    pc_mem [DEPTH];
    logic [DEPTH-1:0]         taken_mem;

    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d, rd_ptr_p1;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, wr_ptr_p1;
    logic [CntW-1:0]          count_q, count_d;
    logic [HISTORY_WIDTH-1:0] ghist_q, ghist_d;
    logic                     overflow_q, overflow_d;

    logic [1:0]               grant;
    logic [1:0]               n_in, n_acc, n_byp, n_wr, n_out, deq;
    logic [ADDR_WIDTH-1:0]    c_pc0, c_pc1, w_pc0, w_pc1;
    logic                     c_tk0, c_tk1, w_tk0, w_tk1;

    assign rd_ptr_p1 = rd_ptr_q + PtrW'(1);
    assign wr_ptr_p1 = wr_ptr_q + PtrW'(1);

    // Only registered occupancy gates enqueue, so a full-width write always fits.
    assign in_ready = (count_q <= CntW'(DEPTH - 2));

    always_comb begin
        unique case (rd_demand)
            2'd0:    grant = 2'd2;
            2'd1:    grant = 2'd1;
            default: grant = 2'd0;
        endcase
    end

    // Compact valid lanes in order: lane 0 first, lane 1 fills the gap if lane 0 idle.
    always_comb begin
        c_pc0 = in_valid[0] ? in_pc[0] : in_pc[1];
        c_tk0 = in_valid[0] ? in_taken[0] : in_taken[1];
        c_pc1 = in_pc[1];
        c_tk1 = in_taken[1];
        n_in  = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
        n_acc = in_ready ? n_in : 2'd0;
    end

    always_comb begin
        deq = (count_q >= CntW'(grant)) ? grant : count_q[1:0];
    end

`ifdef BRFB_BYPASS_EN
    always_comb begin
        n_byp = 2'd0;
        if (count_q == '0 && !reset) begin
            n_byp = (n_acc >= grant) ? grant : n_acc;
        end
    end
`else
    assign n_byp = 2'd0;
`endif

    // Lanes not forwarded are written; if one was forwarded, the remainder is lane c1.
    always_comb begin
        n_wr  = n_acc - n_byp;
        w_pc0 = (n_byp != 2'd0) ? c_pc1 : c_pc0;
        w_tk0 = (n_byp != 2'd0) ? c_tk1 : c_tk0;
        w_pc1 = c_pc1;
        w_tk1 = c_tk1;
    end

    always_comb begin
        out_valid = 2'b00;
        out_pc    = '0;
        out_taken = 2'b00;
        n_out     = deq;
        if (n_byp != 2'd0) begin
            n_out = n_byp;
            out_valid[0] = 1'b1;
            out_pc[0]    = c_pc0;
            out_taken[0] = c_tk0;
            if (n_byp == 2'd2) begin
                out_valid[1] = 1'b1;
                out_pc[1]    = c_pc1;
                out_taken[1] = c_tk1;
            end
        end else begin
            if (deq != 2'd0) begin
                out_valid[0] = 1'b1;
                out_pc[0]    = pc_mem[rd_ptr_q];
                out_taken[0] = taken_mem[rd_ptr_q];
            end
            if (deq == 2'd2) begin
                out_valid[1] = 1'b1;
                out_pc[1]    = pc_mem[rd_ptr_p1];
                out_taken[1] = taken_mem[rd_ptr_p1];
            end
        end
    end

    // Lane 0 is the older branch, so it shifts in first.
    always_comb begin
        ghist_d = ghist_q;
        unique case (n_out)
            2'd1:    ghist_d = {ghist_q[HISTORY_WIDTH-2:0], out_taken[0]};
            2'd2:    ghist_d = {ghist_q[HISTORY_WIDTH-3:0], out_taken[0], out_taken[1]};
            default: ghist_d = ghist_q;
        endcase
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q + PtrW'(deq);
        wr_ptr_d   = wr_ptr_q + PtrW'(n_wr);
        count_d    = count_q + CntW'(n_wr) - CntW'(deq);
        overflow_d = overflow_q | ((|in_valid) & ~in_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ghist_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ghist_q    <= ghist_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (n_wr != 2'd0) begin
            pc_mem[wr_ptr_q]    <= w_pc0;
            taken_mem[wr_ptr_q] <= w_tk0;
        end
        if (n_wr == 2'd2) begin
            pc_mem[wr_ptr_p1]    <= w_pc1;
            taken_mem[wr_ptr_p1] <= w_tk1;
        end
    end

    assign ghist        = ghist_q;
    assign count        = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_branch_fb_queue.sv
// Scoreboard bench for branch_fb_queue (default build, DEPTH 8, HISTORY_WIDTH 14).
module tb_branch_fb_queue;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       in_valid;
    logic [1:0][31:0] in_pc;
    logic [1:0]       in_taken;
    logic             in_ready;
    logic [1:0]       rd_demand;
    logic [1:0]       out_valid;
    logic [1:0][31:0] out_pc;
    logic [1:0]       out_taken;
    logic [13:0]      ghist;
    logic [3:0]       count;
    logic             overflow_err;

    branch_fb_queue #(
        .ADDR_WIDTH   (32),
        .DEPTH        (8),
        .HISTORY_WIDTH(14)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_taken    (in_taken),
        .in_ready    (in_ready),
        .rd_demand   (rd_demand),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_taken   (out_taken),
        .ghist       (ghist),
        .count       (count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
    } ent_t;

    ent_t        sb[$];
    int          mcount;
    logic [13:0] mghist;
    logic        movf;
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive, check at negedge against the model, then advance the model.
    task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                        input logic t0, input logic t1, input logic [1:0] dem);
        int   grant;
        int   deq;
        bit   rdy;
        ent_t e;
        in_valid  = v;
        in_pc[0]  = p0;
        in_pc[1]  = p1;
        in_taken  = {t1, t0};
        rd_demand = dem;
        @(negedge clk);
        rdy = (mcount <= 6);
        check_eq("count", 64'(count), 64'(mcount));
        check_eq("in_ready", 64'(in_ready), 64'(rdy));
        check_eq("ghist", 64'(ghist), 64'(mghist));
        check_eq("overflow_err", 64'(overflow_err), 64'(movf));
        grant = (dem == 2'd0) ? 2 : (dem == 2'd1) ? 1 : 0;
        deq   = (mcount < grant) ? mcount : grant;
        check_eq("out_valid", 64'(out_valid),
                 (deq == 2) ? 64'd3 : (deq == 1) ? 64'd1 : 64'd0);
        for (int i = 0; i < 2; i++) begin
            if (i < deq) begin
                e = sb.pop_front();
                check_eq("out_pc", 64'(out_pc[i]), 64'(e.pc));
                check_eq("out_taken", 64'(out_taken[i]), 64'(e.tk));
                mghist = {mghist[12:0], e.tk};
            end else begin
                check_eq("idle_pc", 64'(out_pc[i]), 64'd0);
                check_eq("idle_taken", 64'(out_taken[i]), 64'd0);
            end
        end
        if (v != 2'b00) begin
            if (rdy) begin
                if (v[0]) begin
                    sb.push_back('{pc: p0, tk: t0});
                    mcount++;
                end
                if (v[1]) begin
                    sb.push_back('{pc: p1, tk: t1});
                    mcount++;
                end
            end else begin
                movf = 1'b1;
            end
        end
        mcount -= deq;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] dem);
        step(2'b00, 32'd0, 32'd0, 1'b0, 1'b0, dem);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mcount    = 0;
        mghist    = '0;
        movf      = 1'b0;
        reset     = 1'b1;
        in_valid  = 2'b00;
        in_pc     = '0;
        in_taken  = 2'b00;
        rd_demand = 2'd0;
        #3;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_ghist", 64'(ghist), 64'd0);
        check_eq("rst_overflow", 64'(overflow_err), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic pair, drained next cycle.
        step(2'b11, 32'h100, 32'h104, 1'b1, 1'b0, 2'd0);
        idle(2'd0);
        check_eq("ghist_after_pair", 64'(ghist), 64'b10);
        check_eq("count_after_pair", 64'(count), 64'd0);

        // Starved by fetch, then single-port drain.
        step(2'b11, 32'h10, 32'h14, 1'b0, 1'b1, 2'd2);
        repeat (3) idle(2'd2);
        idle(2'd1);
        idle(2'd1);

        // Fill to 7, then an attempted write while not ready.
        step(2'b11, 32'h20, 32'h24, 1'b1, 1'b1, 2'd2);
        step(2'b11, 32'h28, 32'h2c, 1'b0, 1'b0, 2'd3);
        step(2'b11, 32'h30, 32'h34, 1'b1, 1'b0, 2'd2);
        step(2'b01, 32'h38, 32'h0, 1'b1, 1'b0, 2'd2);
        step(2'b01, 32'hbad, 32'h0, 1'b1, 1'b0, 2'd2);
        check_eq("ovf_set", 64'(overflow_err), 64'd1);
        check_eq("count_held_7", 64'(count), 64'd7);

        // Steady state at 6: simultaneous enqueue/dequeue across pointer wrap.
        idle(2'd1);
        for (int i = 0; i < 20; i++) begin
            step(2'b11, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'd0);
        end
        check_eq("count_steady_6", 64'(count), 64'd6);
        repeat (4) idle(2'd0);

        // Lane 1 only.
        step(2'b10, 32'hdead, 32'h200, 1'b0, 1'b1, 2'd2);
        check_eq("count_lane1", 64'(count), 64'd1);
        idle(2'd0);

        // Mixed random traffic.
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 2'($urandom));
        end
        repeat (5) idle(2'd0);

        // Reset with entries pending.
        step(2'b11, 32'h500, 32'h504, 1'b1, 1'b1, 2'd2);
        step(2'b11, 32'h508, 32'h50c, 1'b0, 1'b1, 2'd2);
        step(2'b01, 32'h510, 32'h0, 1'b1, 1'b0, 2'd2);
        check_eq("count_5", 64'(count), 64'd5);
        in_valid  = 2'b00;
        rd_demand = 2'd0;
        reset     = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_count", 64'(count), 64'd0);
        check_eq("mid_rst_ghist", 64'(ghist), 64'd0);
        check_eq("mid_rst_overflow", 64'(overflow_err), 64'd0);
        sb.delete();
        mcount = 0;
        mghist = '0;
        movf   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(2'b11, 32'h600, 32'h604, 1'b0, 1'b1, 2'd1);
        idle(2'd0);
        idle(2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
